// File: rtl/fsqrt.sv
// IEEE-754 single-precision square root, fully pipelined: three register stages,
// round-to-nearest-even, denormals flushed to zero.
module fsqrt (
  input  logic        clk,
  input  logic [31:0] a,
  output logic [31:0] s,
  input  logic        rst_n
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  // ---------------- stage A: decode + upper 12 root digits ----------------
  logic        sgn;
  logic [7:0]  ex;
  logic [22:0] fr;
  logic        spec_a;
  logic [31:0] sval_a;
  logic [7:0]  erm1_a;
  logic [49:0] rad_a;
  logic [49:0] xw_a;
  logic [27:0] rem_a;
  logic [24:0] q_a;
  logic [26:0] t_a;

  assign sgn = a[31];
  assign ex  = a[30:23];
  assign fr  = a[22:0];

  always_comb begin
    spec_a = 1'b1;
    sval_a = '0;
    if (ex == 8'd0)
      sval_a = {sgn, 31'b0};
    else if (ex == 8'hFF)
      sval_a = ((fr != 23'd0) || sgn) ? QNAN : PINF;
    else if (sgn)
      sval_a = QNAN;
    else
      spec_a = 1'b0;
  end

  // Result exponent is carried minus one; the root's hidden bit adds it back.
  assign erm1_a = 8'(({1'b0, ex} + 9'd125) >> 1);

  // Odd unbiased exponent (even biased) pre-shifts the significand left by one.
  assign rad_a = ex[0] ? {2'b01, fr, 25'b0} : {1'b1, fr, 26'b0};

  always_comb begin
    rem_a = '0;
    q_a   = '0;
    t_a   = '0;
    xw_a  = rad_a;
    for (int unsigned i = 0; i < 12; i++) begin
      rem_a = {rem_a[25:0], xw_a[49:48]};
      xw_a  = xw_a << 2;
      t_a   = {q_a, 2'b01};
      if (rem_a >= {1'b0, t_a}) begin
        rem_a = rem_a - {1'b0, t_a};
        q_a   = {q_a[23:0], 1'b1};
      end else begin
        q_a   = {q_a[23:0], 1'b0};
      end
    end
  end

  logic        spec1;
  logic [31:0] sval1;
  logic [7:0]  erm1_1;
  logic [27:0] rem1;
  logic [24:0] q1;
  logic [25:0] xlo1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec1  <= 1'b0;
      sval1  <= '0;
      erm1_1 <= '0;
      rem1   <= '0;
      q1     <= '0;
      xlo1   <= '0;
    end else begin
      spec1  <= spec_a;
      sval1  <= sval_a;
      erm1_1 <= erm1_a;
      rem1   <= rem_a;
      q1     <= q_a;
      xlo1   <= rad_a[25:0];
    end
  end

  // ---------------- stage B: lower 13 root digits + sticky ----------------
  logic [25:0] xw_b;
  logic [27:0] rem_b;
  logic [24:0] q_b;
  logic [26:0] t_b;

  always_comb begin
    rem_b = rem1;
    q_b   = q1;
    t_b   = '0;
    xw_b  = xlo1;
    for (int unsigned i = 0; i < 13; i++) begin
      rem_b = {rem_b[25:0], xw_b[25:24]};
      xw_b  = xw_b << 2;
      t_b   = {q_b, 2'b01};
      if (rem_b >= {1'b0, t_b}) begin
        rem_b = rem_b - {1'b0, t_b};
        q_b   = {q_b[23:0], 1'b1};
      end else begin
        q_b   = {q_b[23:0], 1'b0};
      end
    end
  end

  logic        spec2;
  logic [31:0] sval2;
  logic [7:0]  erm1_2;
  logic [24:0] q2;
  logic        sticky2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec2   <= 1'b0;
      sval2   <= '0;
      erm1_2  <= '0;
      q2      <= '0;
      sticky2 <= 1'b0;
    end else begin
      spec2   <= spec1;
      sval2   <= sval1;
      erm1_2  <= erm1_1;
      q2      <= q_b;
      sticky2 <= (rem_b != 28'd0);
    end
  end

  // ---------------- stage C: round to nearest even ----------------
  logic        rnd_up;
  logic [31:0] res_c;

  assign rnd_up = q2[0] & (sticky2 | q2[1]);
  // q2[24] is the hidden one; adding it lands on the exponent field.
  assign res_c  = {1'b0, erm1_2, 23'b0} + {8'b0, q2[24:1]} + {31'b0, rnd_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      s <= '0;
    else
      s <= spec2 ? sval2 : res_c;
  end

endmodule

// File: tb/tb_fsqrt.sv
// Directed and random check of fsqrt: every cycle s is compared against the
// expected result of the operand sampled two rising edges earlier.
module tb_fsqrt;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] s;

  int unsigned total;
  int unsigned passed;
  int unsigned failed;

  logic [31:0] pa [3];
  logic [31:0] pe [3];

  fsqrt dut (
    .clk   (clk),
    .a     (a),
    .s     (s),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: double-precision sqrt (exact for float inputs), then manual RNE to float.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] f;
    logic [10:0] de;
    logic [63:0] db;
    logic [7:0]  re;
    logic        up;
    real         d;
    real         r;
    e = x[30:23];
    f = x[22:0];
    if (e == 8'd0) return {x[31], 31'b0};
    if (e == 8'hFF) return ((f != 23'd0) || x[31]) ? 32'h7FC0_0000 : 32'h7F80_0000;
    if (x[31]) return 32'h7FC0_0000;
    de = {3'b0, e} + 11'd896;
    d  = $bitstoreal({1'b0, de, f, 29'b0});
    r  = $sqrt(d);
    db = $realtobits(r);
    re = 8'(db[62:52] - 11'd896);
    up = db[28] & ((db[27:0] != 28'd0) | db[29]);
    return {1'b0, re, db[51:29]} + {31'b0, up};
  endfunction

  task automatic check(input logic [31:0] tag, input logic [31:0] ev);
    total++;
    assert (s === ev) passed++;
    else begin
      failed++;
      $error("FAIL s[a=%h] got %h want %h", tag, s, ev);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < 3; i++) begin
      pa[i] = 32'h0;
      pe[i] = 32'h0;
    end
  endtask

  task automatic step(input logic [31:0] av, input logic [31:0] ev);
    a = av;
    @(posedge clk);
    #1;
    pa[2] = pa[1]; pe[2] = pe[1];
    pa[1] = pa[0]; pe[1] = pe[0];
    pa[0] = av;    pe[0] = ev;
    check(pa[2], pe[2]);
  endtask

  initial begin
    logic [31:0] r;
    total  = 0;
    passed = 0;
    failed = 0;
    clear_pipe();
    rst_n = 1'b0;
    a     = 32'h4080_0000;
    #2;
    check(32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    a     = 32'h0;
    rst_n = 1'b1;

    // idle zeros after reset
    step(32'h0000_0000, 32'h0000_0000);
    step(32'h0000_0000, 32'h0000_0000);

    // streaming basics
    step(32'h4080_0000, 32'h4000_0000);
    step(32'h3F80_0000, 32'h3F80_0000);
    step(32'h3E80_0000, 32'h3F00_0000);
    // rounding
    step(32'h4000_0000, 32'h3FB5_04F3);
    step(32'h4040_0000, 32'h3FDD_B3D7);
    step(32'h4110_0000, 32'h4040_0000);
    // specials
    step(32'h0000_0000, 32'h0000_0000);
    step(32'h8000_0000, 32'h8000_0000);
    step(32'h0000_0001, 32'h0000_0000);
    step(32'h8000_0001, 32'h8000_0000);
    step(32'h7F80_0000, 32'h7F80_0000);
    step(32'hBF80_0000, 32'h7FC0_0000);
    step(32'h7FC0_0001, 32'h7FC0_0000);
    step(32'hFF80_0000, 32'h7FC0_0000);
    // exponent extremes
    step(32'h0080_0000, 32'h2000_0000);
    step(32'h7F7F_FFFF, 32'h5F7F_FFFF);

    // random positive normals
    for (int i = 0; i < 1000; i++) begin
      r = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
      step(r, ref_sqrt(r));
    end
    step(32'h0, 32'h0);
    step(32'h0, 32'h0);

    // reset mid-stream: in-flight 2.0 and 1.0 must be discarded
    step(32'h4080_0000, 32'h4000_0000);
    step(32'h4000_0000, 32'h3FB5_04F3);
    step(32'h3F80_0000, 32'h3F80_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check(32'hDEAD_0000, 32'h0000_0000);
    clear_pipe();
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h4110_0000, 32'h4040_0000);
    step(32'h0000_0000, 32'h0000_0000);
    step(32'h0000_0000, 32'h0000_0000);
    step(32'h0000_0000, 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
